decode_ctrl_pipe: RTL and testbench

DECODE_CTRL_PIPE -- requirements
Module: decode_ctrl_pipe

---
 rtl/decode_ctrl_pipe.sv | 254 +++++++++++++++++++++++++
 tb/tb_decode_ctrl_pipe.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_ctrl_pipe.sv
// Decode-stage control with registered EX outputs, hi/lo interlock and GPIO decode.
// Define CTRL_BRANCH_EN to enable beq/bne resolution (BR_RESOLVE state, pc_src_EX).
package decode_ctrl_pipe_pkg;
  typedef struct packed {
    logic [3:0] alu_op;
    logic [4:0] shamt;
    logic       enhilo;
    logic [1:0] regsel;
    logic       regwrite;
    logic       rdrt;
    logic [1:0] alu_src;
    logic       illegal;
  } ex_ctrl_t;
endpackage

module decode_ctrl_pipe
  import decode_ctrl_pipe_pkg::*;
#(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned GPIO_CH  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [31:0]        instr,
  input  logic               stall_in,
  input  logic               flush,
  input  logic               zero_EX,
  output logic [3:0]         alu_op,
  output logic [4:0]         shamt_EX,
  output logic               enhilo_EX,
  output logic [1:0]         regsel_EX,
  output logic               regwrite_EX,
  output logic               rdrt_EX,
  output logic [1:0]         alu_src_EX,
  output logic [GPIO_CH-1:0] gpio_out_en,
  output logic [GPIO_CH-1:0] gpio_in_en,
  output logic               pc_src_EX,
  output logic               stall_FETCH,
  output logic               illegal_EX,
  output logic               mult_busy
);
  localparam int unsigned CntW = 4;
`ifdef CTRL_BRANCH_EN
  localparam bit BranchEn = 1'b1;
`else
  localparam bit BranchEn = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, MULT_BUSY = 2'd1, BR_RESOLVE = 2'd2} state_t;

  state_t             state, state_nx;
  logic [CntW-1:0]    cnt, cnt_nx;
  ex_ctrl_t           ex_q, ex_nx, dec;
  logic [GPIO_CH-1:0] gpo_q, gpo_nx, gpi_q, gpi_nx, dec_gpo, dec_gpi, gpio_sel;
  logic               pc_q, pc_nx, stall_q, stall_nx, busy_q, busy_nx, bne_q, bne_nx;
  logic               dec_mult, dec_hilo, dec_br, dec_bne, rd_ok;
  logic [5:0]         opcode, funct;
  logic [4:0]         rd, shamt;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign rd_ok  = (32'(rd) < GPIO_CH);

  always_comb begin
    gpio_sel = '0;
    for (int i = 0; i < int'(GPIO_CH); i++) gpio_sel[i] = (rd == 5'(i));
  end

  // Instruction decode; the all-zero word is a NOP, not sll.
  always_comb begin
    dec      = '0;
    dec_gpo  = '0;
    dec_gpi  = '0;
    dec_mult = 1'b0;
    dec_hilo = 1'b0;
    dec_br   = 1'b0;
    dec_bne  = 1'b0;
    if (instr == 32'd0) begin
      dec = '0;
    end else if (opcode == 6'd0) begin
      dec.regwrite = 1'b1;
      case (funct)
        6'h20, 6'h21: dec.alu_op = 4'b0100;
        6'h22, 6'h23: dec.alu_op = 4'b0101;
        6'h18, 6'h19: begin
          dec.alu_op   = {3'b011, funct[0]};
          dec.regwrite = 1'b0;
          dec.enhilo   = 1'b1;
          dec_mult     = 1'b1;
          dec_hilo     = 1'b1;
        end
        6'h24: dec.alu_op = 4'b0000;
        6'h25: dec.alu_op = 4'b0001;
        6'h27: dec.alu_op = 4'b0010;
        6'h26: dec.alu_op = 4'b0011;
        6'h2a: dec.alu_op = 4'b1100;
        6'h2b: dec.alu_op = 4'b1101;
        6'h00: begin
          dec.alu_op = 4'b1000;
          dec.shamt  = shamt;
        end
        6'h02: begin
          if (shamt == 5'd0) begin
            dec.regwrite = 1'b0;
            if (rd_ok) dec_gpo = gpio_sel;
            else       dec.illegal = 1'b1;
          end else begin
            dec.alu_op = 4'b1001;
            dec.shamt  = shamt;
          end
        end
        6'h03: begin
          if (shamt == 5'd0) begin
            if (rd_ok) begin
              dec_gpi = gpio_sel;
            end else begin
              dec.regwrite = 1'b0;
              dec.illegal  = 1'b1;
            end
          end else begin
            dec.alu_op = 4'b1010;
            dec.shamt  = shamt;
          end
        end
        6'h10: begin
          dec.regsel = 2'b01;
          dec_hilo   = 1'b1;
        end
        6'h12: begin
          dec.regsel = 2'b10;
          dec_hilo   = 1'b1;
        end
        default: begin
          dec.regwrite = 1'b0;
          dec.illegal  = 1'b1;
        end
      endcase
    end else begin
      case (opcode)
        6'h0f: begin dec.alu_op = 4'b1000; dec.shamt = 5'd16; dec.rdrt = 1'b1; dec.regwrite = 1'b1; end
        6'h08, 6'h09: begin dec.alu_op = 4'b0100; dec.alu_src = 2'd1; dec.rdrt = 1'b1; dec.regwrite = 1'b1; end
        6'h0c: begin dec.alu_op = 4'b0000; dec.alu_src = 2'd2; dec.rdrt = 1'b1; dec.regwrite = 1'b1; end
        6'h0d: begin dec.alu_op = 4'b0001; dec.alu_src = 2'd2; dec.rdrt = 1'b1; dec.regwrite = 1'b1; end
        6'h0e: begin dec.alu_op = 4'b0011; dec.alu_src = 2'd2; dec.rdrt = 1'b1; dec.regwrite = 1'b1; end
        6'h0a: begin dec.alu_op = 4'b1100; dec.alu_src = 2'd1; dec.rdrt = 1'b1; dec.regwrite = 1'b1; end
        6'h04, 6'h05: begin
          if (BranchEn) begin
            dec.alu_op = 4'b0101;
            dec_br     = 1'b1;
            dec_bne    = opcode[0];
          end else begin
            dec.illegal = 1'b1;
          end
        end
        default: dec.illegal = 1'b1;
      endcase
    end
  end

  // Next state: flush > stall_in > post-redirect discard > branch resolve > hi/lo hold > issue.
  always_comb begin
    state_nx = state;
    ex_nx    = ex_q;
    gpo_nx   = gpo_q;
    gpi_nx   = gpi_q;
    pc_nx    = pc_q;
    bne_nx   = bne_q;
    stall_nx = 1'b0;
    cnt_nx   = (cnt != '0) ? cnt - CntW'(1) : '0;
    if (flush) begin
      ex_nx    = '0;
      gpo_nx   = '0;
      gpi_nx   = '0;
      pc_nx    = 1'b0;
      state_nx = (cnt_nx != '0) ? MULT_BUSY : IDLE;
    end else if (stall_in) begin
      stall_nx = 1'b1;
    end else begin
      ex_nx    = '0;
      gpo_nx   = '0;
      gpi_nx   = '0;
      pc_nx    = 1'b0;
      state_nx = (cnt_nx != '0) ? MULT_BUSY : IDLE;
      if (pc_q) begin
        // slot after a taken branch holds a wrong-path instruction
        stall_nx = 1'b0;
      end else if (state == BR_RESOLVE) begin
        stall_nx = 1'b1;
        pc_nx    = bne_q ^ zero_EX;
      end else if (instr_valid && dec_hilo && (cnt != '0)) begin
        stall_nx = 1'b1;
      end else if (instr_valid) begin
        ex_nx  = dec;
        gpo_nx = dec_gpo;
        gpi_nx = dec_gpi;
        if (dec_mult) begin
          cnt_nx   = CntW'(MULT_LAT);
          state_nx = MULT_BUSY;
        end
        if (dec_br) begin
          state_nx = BR_RESOLVE;
          bne_nx   = dec_bne;
        end
      end
    end
    busy_nx = (cnt_nx != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ex_q    <= '0;
      gpo_q   <= '0;
      gpi_q   <= '0;
      pc_q    <= 1'b0;
      bne_q   <= 1'b0;
      stall_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      ex_q    <= ex_nx;
      gpo_q   <= gpo_nx;
      gpi_q   <= gpi_nx;
      pc_q    <= pc_nx;
      bne_q   <= bne_nx;
      stall_q <= stall_nx;
      busy_q  <= busy_nx;
    end
  end

  assign alu_op      = ex_q.alu_op;
  assign shamt_EX    = ex_q.shamt;
  assign enhilo_EX   = ex_q.enhilo;
  assign regsel_EX   = ex_q.regsel;
  assign regwrite_EX = ex_q.regwrite;
  assign rdrt_EX     = ex_q.rdrt;
  assign alu_src_EX  = ex_q.alu_src;
  assign illegal_EX  = ex_q.illegal;
  assign gpio_out_en = gpo_q;
  assign gpio_in_en  = gpi_q;
  assign stall_FETCH = stall_q;
  assign mult_busy   = busy_q;
`ifdef CTRL_BRANCH_EN
  assign pc_src_EX   = pc_q;
`else
  assign pc_src_EX   = 1'b0;
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Bench for decode_ctrl_pipe: directed vectors, per-cycle model compare, literal pins.
module tb_decode_ctrl_pipe;
  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned GPIO_CH  = 2;
  localparam int K_NOP = 0, K_ALU = 1, K_MULT = 2, K_HILO = 3, K_BR = 4, K_ILL = 5;

  localparam logic [31:0] ADD   = 32'h00221820;
  localparam logic [31:0] OR_I  = 32'h00221825;
  localparam logic [31:0] MULT  = 32'h00220018;
  localparam logic [31:0] MULTU = 32'h00220019;
  localparam logic [31:0] MFLO  = 32'h00002012;
  localparam logic [31:0] MFHI  = 32'h00001810;
  localparam logic [31:0] BEQ   = 32'h10220003;
  localparam logic [31:0] BNE   = 32'h14220003;

  typedef struct packed {
    logic [3:0]         alu_op;
    logic [4:0]         shamt;
    logic               enhilo;
    logic [1:0]         regsel;
    logic               regwrite;
    logic               rdrt;
    logic [1:0]         alu_src;
    logic [GPIO_CH-1:0] gpo;
    logic [GPIO_CH-1:0] gpi;
    logic               illegal;
  } ex_t;

  logic clk = 1'b0;
  logic rst, instr_valid, stall_in, flush, zero_EX;
  logic [31:0] instr;
  logic [3:0] alu_op;
  logic [4:0] shamt_EX;
  logic enhilo_EX, regwrite_EX, rdrt_EX, pc_src_EX, stall_FETCH, illegal_EX, mult_busy;
  logic [1:0] regsel_EX, alu_src_EX;
  logic [GPIO_CH-1:0] gpio_out_en, gpio_in_en;

  decode_ctrl_pipe #(.MULT_LAT(MULT_LAT), .GPIO_CH(GPIO_CH)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
    .stall_in(stall_in), .flush(flush), .zero_EX(zero_EX),
    .alu_op(alu_op), .shamt_EX(shamt_EX), .enhilo_EX(enhilo_EX),
    .regsel_EX(regsel_EX), .regwrite_EX(regwrite_EX), .rdrt_EX(rdrt_EX),
    .alu_src_EX(alu_src_EX), .gpio_out_en(gpio_out_en), .gpio_in_en(gpio_in_en),
    .pc_src_EX(pc_src_EX), .stall_FETCH(stall_FETCH), .illegal_EX(illegal_EX),
    .mult_busy(mult_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  wire [23:0] dut_v = {alu_op, shamt_EX, enhilo_EX, regsel_EX, regwrite_EX, rdrt_EX,
                       alu_src_EX, gpio_out_en, gpio_in_en, illegal_EX,
                       pc_src_EX, stall_FETCH, mult_busy};

  // Expected EX control straight from the opcode/funct tables.
  function automatic void model_decode(input logic [31:0] w, output ex_t e, output int kind);
    int op, fn, rd, sh;
    op = int'(w[31:26]); fn = int'(w[5:0]); rd = int'(w[15:11]); sh = int'(w[10:6]);
    e = '0;
    kind = K_ALU;
    if (w == 32'd0) begin
      kind = K_NOP;
    end else if (op == 0) begin
      e.regwrite = 1'b1;
      case (fn)
        'h20, 'h21: e.alu_op = 4'd4;
        'h22, 'h23: e.alu_op = 4'd5;
        'h18: begin e.alu_op = 4'd6; e.regwrite = 1'b0; e.enhilo = 1'b1; kind = K_MULT; end
        'h19: begin e.alu_op = 4'd7; e.regwrite = 1'b0; e.enhilo = 1'b1; kind = K_MULT; end
        'h24: e.alu_op = 4'd0;
        'h25: e.alu_op = 4'd1;
        'h27: e.alu_op = 4'd2;
        'h26: e.alu_op = 4'd3;
        'h2a: e.alu_op = 4'd12;
        'h2b: e.alu_op = 4'd13;
        'h00: begin e.alu_op = 4'd8; e.shamt = 5'(sh); end
        'h02, 'h03: begin
          if (sh != 0) begin
            e.alu_op = (fn == 'h02) ? 4'd9 : 4'd10;
            e.shamt  = 5'(sh);
          end else begin
            e = '0;
            if (rd >= int'(GPIO_CH)) begin
              e.illegal = 1'b1;
              kind = K_ILL;
            end else if (fn == 'h02) begin
              e.gpo = GPIO_CH'(1) << rd;
            end else begin
              e.gpi = GPIO_CH'(1) << rd;
              e.regwrite = 1'b1;
            end
          end
        end
        'h10: begin e.regsel = 2'b01; kind = K_HILO; end
        'h12: begin e.regsel = 2'b10; kind = K_HILO; end
        default: begin e = '0; e.illegal = 1'b1; kind = K_ILL; end
      endcase
    end else begin
      e.rdrt = 1'b1;
      e.regwrite = 1'b1;
      case (op)
        'h0f: begin e.alu_op = 4'd8; e.shamt = 5'd16; end
        'h08, 'h09: begin e.alu_op = 4'd4; e.alu_src = 2'd1; end
        'h0c: begin e.alu_op = 4'd0; e.alu_src = 2'd2; end
        'h0d: begin e.alu_op = 4'd1; e.alu_src = 2'd2; end
        'h0e: begin e.alu_op = 4'd3; e.alu_src = 2'd2; end
        'h0a: begin e.alu_op = 4'd12; e.alu_src = 2'd1; end
`ifdef CTRL_BRANCH_EN
        'h04, 'h05: begin e = '0; e.alu_op = 4'd5; kind = K_BR; end
`endif
        default: begin e = '0; e.illegal = 1'b1; kind = K_ILL; end
      endcase
    end
  endfunction

  ex_t m_ex;
  logic m_pc, m_stall, m_busy;
  int  m_left;
  bit  m_brw, m_bne, m_redir;

  // Behavioural model: hi/lo busy as a cycle count, branch as a pending flag.
  always @(posedge clk) begin
    ex_t d;
    int k;
    int left_nx;
    model_decode(instr, d, k);
    if (!rst) begin
      m_ex = '0; m_pc = 0; m_stall = 0; m_busy = 0;
      m_left = 0; m_brw = 0; m_bne = 0; m_redir = 0;
    end else begin
      left_nx = (m_left > 0) ? m_left - 1 : 0;
      if (flush) begin
        m_ex = '0; m_pc = 0; m_stall = 0; m_brw = 0; m_redir = 0;
      end else if (stall_in) begin
        m_stall = 1;
      end else begin
        m_stall = 0; m_pc = 0; m_ex = '0;
        if (m_redir) begin
          m_redir = 0;
        end else if (m_brw) begin
          m_brw = 0;
          m_stall = 1;
          m_pc = m_bne ? !zero_EX : zero_EX;
          m_redir = m_pc;
        end else if (instr_valid && (k == K_MULT || k == K_HILO) && m_left > 0) begin
          m_stall = 1;
        end else if (instr_valid) begin
          m_ex = d;
          if (k == K_MULT) left_nx = int'(MULT_LAT);
          if (k == K_BR) begin m_brw = 1; m_bne = instr[26]; end
        end
      end
      m_left = left_nx;
      m_busy = (m_left > 0);
    end
  end

  always @(posedge clk) begin
    #1;
    n_cmp++;
    if (dut_v !== {m_ex, m_pc, m_stall, m_busy}) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t instr=%h dut=%h model=%h", $time, instr, dut_v,
               {m_ex, m_pc, m_stall, m_busy});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] w, input logic st = 1'b0,
                     input logic fl = 1'b0, input logic z = 1'b0);
    @(negedge clk);
    instr_valid = v; instr = w; stall_in = st; flush = fl; zero_EX = z;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] tbl [0:11];

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr = 32'd0; stall_in = 1'b0; flush = 1'b0; zero_EX = 1'b0;
    tbl = '{ADD, MULT, MFHI, OR_I, 32'h00021940, 32'h3C011234, 32'h00020803,
            32'h00021803, MULTU, MFLO, BNE, 32'h0022183F};
    cyc(1'b0, 32'd0);
    cyc(1'b1, MULT);
    chk("reset_all_zero", 32'(dut_v), 32'd0);
    rst = 1'b1;

    cyc(1'b1, ADD);
    chk("add_alu_op", 32'(alu_op), 32'h4);
    chk("add_regwrite", 32'(regwrite_EX), 32'h1);
    chk("add_rdrt", 32'(rdrt_EX), 32'h0);
    chk("add_regsel", 32'(regsel_EX), 32'h0);
    cyc(1'b1, 32'h00021940);
    chk("sll_op_shamt", 32'({alu_op, shamt_EX}), 32'({4'b1000, 5'd5}));
    cyc(1'b1, 32'd0);
    chk("nop_bubble", 32'(dut_v), 32'd0);
    cyc(1'b1, 32'h3C011234);
    chk("lui_fields", 32'({alu_op, shamt_EX, rdrt_EX, regwrite_EX, alu_src_EX}),
        32'({4'b1000, 5'd16, 1'b1, 1'b1, 2'd0}));
    cyc(1'b1, 32'h34210005);
    chk("ori_fields", 32'({alu_op, alu_src_EX}), 32'({4'b0001, 2'd2}));
    cyc(1'b1, 32'h28220007);
    chk("slti_fields", 32'({alu_op, alu_src_EX}), 32'({4'b1100, 2'd1}));
    cyc(1'b1, 32'hFC000000);
    chk("bad_opcode_illegal", 32'({illegal_EX, regwrite_EX, alu_op}), 32'({1'b1, 1'b0, 4'd0}));
    cyc(1'b1, 32'h0022183F);
    cyc(1'b1, 32'h00020803);
    chk("gpio_in_rd1", 32'({gpio_in_en, regwrite_EX, illegal_EX}), 32'({2'b10, 1'b1, 1'b0}));
    cyc(1'b1, 32'h00021803);
    chk("gpio_in_rd3_illegal", 32'({gpio_in_en, regwrite_EX, illegal_EX}), 32'({2'b00, 1'b0, 1'b1}));
    cyc(1'b1, 32'h00020002);
    chk("gpio_out_rd0", 32'({gpio_out_en, regwrite_EX}), 32'({2'b01, 1'b0}));

    cyc(1'b1, MULTU);
    chk("multu_fields", 32'({alu_op, enhilo_EX, regwrite_EX, mult_busy}), 32'({4'b0111, 1'b1, 1'b0, 1'b1}));
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, MFLO);
      chk("mflo_held_stall", 32'(stall_FETCH), 32'h1);
      chk("mflo_held_bubble", 32'({alu_op, regsel_EX, regwrite_EX}), 32'd0);
    end
    cyc(1'b1, MFLO);
    chk("mflo_issue", 32'({regsel_EX, regwrite_EX, stall_FETCH, mult_busy}), 32'({2'b10, 1'b1, 1'b0, 1'b0}));

    cyc(1'b1, MULT);
    cyc(1'b1, ADD);
    chk("add_during_mult", 32'({alu_op, stall_FETCH, mult_busy}), 32'({4'b0100, 1'b0, 1'b1}));
    cyc(1'b1, OR_I, 1'b1);
    chk("stall_in_freeze", 32'({alu_op, stall_FETCH}), 32'({4'b0100, 1'b1}));
    cyc(1'b1, OR_I);
    chk("after_stall_issue", 32'(alu_op), 32'h1);
    cyc(1'b1, ADD, 1'b1, 1'b1);
    chk("flush_and_stall", 32'({alu_op, regwrite_EX, stall_FETCH}), 32'd0);
    cyc(1'b0, 32'd0);

    cyc(1'b1, MULT);
    cyc(1'b1, MFHI);
    chk("mfhi_held", 32'(stall_FETCH), 32'h1);
    rst = 1'b0;
    cyc(1'b1, MFHI);
    chk("reset_mid_mult", 32'({mult_busy, stall_FETCH}), 32'd0);
    rst = 1'b1;
    cyc(1'b1, MFHI);
    chk("mfhi_after_reset", 32'({regsel_EX, regwrite_EX, stall_FETCH}), 32'({2'b01, 1'b1, 1'b0}));

`ifdef CTRL_BRANCH_EN
    cyc(1'b1, BNE);
    chk("bne_issue", 32'({alu_op, regwrite_EX, pc_src_EX}), 32'({4'b0101, 1'b0, 1'b0}));
    cyc(1'b1, ADD, 1'b0, 1'b0, 1'b0);
    chk("bne_taken_pc", 32'({pc_src_EX, stall_FETCH, alu_op}), 32'({1'b1, 1'b1, 4'd0}));
    cyc(1'b1, ADD);
    chk("bne_taken_discard", 32'({pc_src_EX, alu_op, regwrite_EX}), 32'd0);
    cyc(1'b1, OR_I);
    chk("after_redirect_issue", 32'(alu_op), 32'h1);
    cyc(1'b1, BNE);
    cyc(1'b1, ADD, 1'b0, 1'b0, 1'b1);
    chk("bne_not_taken", 32'({pc_src_EX, stall_FETCH}), 32'({1'b0, 1'b1}));
    cyc(1'b1, ADD);
    chk("bne_nt_release", 32'({alu_op, pc_src_EX}), 32'({4'b0100, 1'b0}));
    cyc(1'b1, BEQ);
    cyc(1'b1, ADD, 1'b0, 1'b0, 1'b1);
    chk("beq_taken_pc", 32'(pc_src_EX), 32'h1);
    cyc(1'b1, ADD);
    cyc(1'b1, BEQ);
    cyc(1'b1, ADD, 1'b1, 1'b1, 1'b1);
    chk("br_flush_stall", 32'(dut_v), 32'd0);
    cyc(1'b1, ADD);
    chk("br_flush_idle", 32'({alu_op, stall_FETCH, pc_src_EX}), 32'({4'b0100, 1'b0, 1'b0}));
`else
    cyc(1'b1, BEQ);
    chk("beq_illegal", 32'({illegal_EX, pc_src_EX, alu_op}), 32'({1'b1, 1'b0, 4'd0}));
    cyc(1'b1, BNE, 1'b0, 1'b0, 1'b0);
    chk("bne_illegal", 32'({illegal_EX, pc_src_EX}), 32'({1'b1, 1'b0}));
`endif

    for (int i = 0; i < 48; i++)
      cyc((i % 7) != 3, tbl[i % 12], (i % 5) == 2, (i % 11) == 6, 1'(i % 2));
    cyc(1'b0, 32'd0);
    cyc(1'b0, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
